// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: one 1-bit ALU slice, LSB first, WIDTH+1 cycles per op.
// Optional abort input is compiled in with `define ALU_SERIAL_ABORT_EN.
module alu_serial_seq #(
   parameter int WIDTH = 64,
   parameter int CNT_W = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef ALU_SERIAL_ABORT_EN
   input  logic             abort,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             cout
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   localparam logic [1:0]       SEL_AND  = 2'b00;
   localparam logic [1:0]       SEL_OR   = 2'b01;
   localparam logic [1:0]       SEL_ADD  = 2'b10;
   localparam logic [1:0]       SEL_SLT  = 2'b11;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

   state_t           r_state;
   state_t           w_next;

   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_res_sh;
   logic [3:0]       r_op;
   logic             r_carry;
   logic [CNT_W-1:0] r_idx;
   logic             r_c_in_msb;
   logic             r_c_out_msb;
   logic             r_sum_msb;

   logic             w_abort;
   logic             w_ai;
   logic             w_bi;
   logic             w_sum;
   logic             w_carry_out;
   logic             w_bit;
   logic             w_last;
   logic             w_ovf;
   logic             w_arith;
   logic [WIDTH-1:0] w_final;

`ifdef ALU_SERIAL_ABORT_EN
   assign w_abort = abort;
`else
   assign w_abort = 1'b0;
`endif

   // One ALU slice, fed from the bottom of the operand shift registers.
   assign w_ai        = r_a_sh[0] ^ r_op[3];
   assign w_bi        = r_b_sh[0] ^ r_op[2];
   assign w_sum       = w_ai ^ w_bi ^ r_carry;
   assign w_carry_out = (w_ai & w_bi) | (r_carry & (w_ai ^ w_bi));

   // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      w_bit = 1'b0;
      case (r_op[1:0])
         SEL_AND: w_bit = w_ai & w_bi;
         SEL_OR:  w_bit = w_ai | w_bi;
         SEL_ADD: w_bit = w_sum;
         SEL_SLT: w_bit = 1'b0;
         default: w_bit = 1'b0;
      endcase
   end

   assign w_last  = (r_idx == LAST_IDX);
   assign w_ovf   = r_c_in_msb ^ r_c_out_msb;
   assign w_arith = r_op[1];

   // SLT replaces the shifted zeros with the overflow-corrected sign of A-B.
   assign w_final = (r_op[1:0] == SEL_SLT) ?
                    {{(WIDTH-1){1'b0}}, r_sum_msb ^ w_ovf} : r_res_sh;

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (start) w_next = S_RUN;
         end
         S_RUN: begin
            if (w_abort)     w_next = S_IDLE;
            else if (w_last) w_next = S_FIN;
         end
         S_FIN: begin
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign busy = (r_state != S_IDLE);

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_a_sh      <= '0;
         r_b_sh      <= '0;
         r_res_sh    <= '0;
         r_op        <= '0;
         r_carry     <= 1'b0;
         r_idx       <= '0;
         r_c_in_msb  <= 1'b0;
         r_c_out_msb <= 1'b0;
         r_sum_msb   <= 1'b0;
         done        <= 1'b0;
         result      <= '0;
         zero        <= 1'b0;
         overflow    <= 1'b0;
         cout        <= 1'b0;
      end else begin
         r_state <= w_next;
         done    <= 1'b0;

         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a_sh  <= a;
                  r_b_sh  <= b;
                  r_op    <= op;
                  r_carry <= op[2];
                  r_idx   <= '0;
               end
            end

            S_RUN: begin
               r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
               r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
               r_res_sh <= {w_bit, r_res_sh[WIDTH-1:1]};
               r_carry  <= w_carry_out;
               r_idx    <= r_idx + CNT_W'(1);
               if (w_last) begin
                  r_c_in_msb  <= r_carry;
                  r_c_out_msb <= w_carry_out;
                  r_sum_msb   <= w_sum;
               end
            end

            S_FIN: begin
               if (!w_abort) begin
                  result   <= w_final;
                  zero     <= (w_final == '0);
                  overflow <= w_arith & w_ovf;
                  cout     <= w_arith & r_c_out_msb;
                  done     <= 1'b1;
               end
            end

            default: ;
         endcase
      end
   end

endmodule

// File: doc/alu_serial_seq.md
Name: alu_serial_seq

Overview:
- Sequencer that computes a WIDTH-bit ALU operation with one 1-bit ALU slice, time-multiplexed one bit per clock, LSB first.
- The slice has A/B invert, a 4:1 result select (AND/OR/SUM/LESS) and a full adder.
- The block owns operand shifting, the carry register, LESS feedback and flag generation.
- Used as the area-minimal ALU option in the multi-cycle core; the pipeline wrapper waits on busy/done.

Parameters:
- WIDTH, 64, operand and result width in bits (>=2).
- CNT_W, 7, bit-index counter width (must satisfy 2^CNT_W > WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; accepted only in IDLE.
- op  input  4  op[3]=ainvert, op[2]=binvert, op[1:0]=select (00 AND, 01 OR, 10 ADD, 11 SLT).
- a  input  WIDTH  operand A; sampled on the accept edge.
- b  input  WIDTH  operand B; sampled on the accept edge.
- busy  output  1  high in RUN and FIN.
- done  output  1  one-cycle pulse; result and flags are valid.
- result  output  WIDTH  result; held until the next accept.
- zero  output  1  result == 0.
- overflow  output  1  signed overflow (select 10/11 only, else 0).
- cout  output  1  carry out of MSB (select 10/11 only, else 0).

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous, active-low. While rst_n=0 at a rising edge: state=IDLE; busy, done, result, zero, overflow, cout all 0; internal registers cleared.
- Reset mid-operation: the operation is discarded, no done pulse is produced, and the block is back in IDLE on the next edge.
- IDLE, start=1 at an edge:
  - latch a, b and op into shift registers;
  - carry_reg <= op[2] (binvert seeds carry-in, so 0110 = SUB);
  - idx <= 0;
  - go to RUN.
- RUN, each edge evaluates the slice on a_sh[0], b_sh[0], carry_reg:
  - Slice inputs: ai = a_sh[0]^op[3], bi = b_sh[0]^op[2].
  - Bit result by select: AND = ai&bi; OR = ai|bi; ADD = ai^bi^carry; SLT = 0, with the LESS value patched in at FIN.
  - The bit result shifts into result_sh MSB-first (after WIDTH shifts, bit 0 is in place).
  - carry_reg <= carry out; a_sh and b_sh shift right; idx increments.
  - When idx == WIDTH-1: capture c_in_msb = carry_reg (pre-update), sum_msb and c_out_msb, then go to FIN.
- FIN, one cycle:
  - result <= result_sh, except for SLT, where result = {0..., sum_msb ^ ovf}.
  - ovf = c_in_msb ^ c_out_msb.
  - overflow <= ovf and cout <= c_out_msb for select 1x, else 0.
  - zero computed from the final result.
  - done <= 1; go to IDLE.
- Latency: start accepted at edge 0; done=1 in the cycle after edge WIDTH+1 (WIDTH+1 edges). Back-to-back: a start in the same cycle as done is accepted.
- done is high exactly one cycle. Outputs are stable from done until the next accept edge.
- start while busy is ignored, with no queuing.
- Changes on a, b and op after the accept edge have no effect.
- AND/OR operations still take the full WIDTH cycles; there is no early exit.

Optional Feature:
- Macro ALU_SERIAL_ABORT_EN.
- Defined:
  - Adds port abort (input, 1).
  - abort=1 at an edge in RUN or FIN returns to IDLE with no done; result and flags keep their previous values; busy drops the next cycle.
  - abort has priority over a FIN completion. It is ignored in IDLE; a simultaneous start in IDLE is still accepted.
- Undefined: no abort port; behaviour is as above.

Test Plan:
- Reset then ADD (op=0010), a=5, b=3, start one cycle -> done at edge 65; result=8, zero=0, cout=0, overflow=0; busy high for edges 1..65.
- SUB (op=0110), a=3, b=5 -> result=0xFFFF_FFFF_FFFF_FFFE, cout=0, overflow=0. Then a=b=7 -> result=0, zero=1, cout=1.
- SUB, a=0x8000_0000_0000_0000, b=1 -> result=0x7FFF_FFFF_FFFF_FFFF, overflow=1. SLT (op=0111) with the same operands -> result=1 (overflow-corrected).
- SLT, a=-1, b=1 -> result=1. AND a=0xF0F0, b=0xFF00 -> 0xF000. OR -> 0xFFF0. NOR (op=1100), a=b=0 -> all ones, overflow=0, cout=0.
- start pulsed again at edge 10 with different operands -> ignored; first result intact. start held high across done -> second op accepted in the done cycle, next done 65 edges later.
- rst_n=0 for one edge at idx=30 -> IDLE next cycle, all outputs 0, no done. If ALU_SERIAL_ABORT_EN: abort at idx=20 -> no done, prior result retained.
